// File: rtl/audio_frame_pkg.sv
// Shared constants and FSM encoding for the audio frame packer.
// Optional checksum trailer is enabled by defining AUDIO_FRAME_CSUM_EN.
package audio_frame_pkg;

    localparam logic [7:0] HDR_MAGIC0    = 8'hA5;
    localparam logic [7:0] HDR_MAGIC1    = 8'h5A;
    localparam int         HDR_LEN       = 4;
    localparam logic [7:0] DROP_CNT_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CSUM    = 2'd3
    } afp_state_t;

    // Header byte idx of a frame carrying sequence number seq.
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] seq);
        case (idx)
            2'd0:    hdr_byte = HDR_MAGIC0;
            2'd1:    hdr_byte = HDR_MAGIC1;
            2'd2:    hdr_byte = seq[15:8];
            default: hdr_byte = seq[7:0];
        endcase
    endfunction

endpackage

// File: rtl/afp_pingpong_buf.sv
// Two-bank sample store: write side fills banks alternately, read side drains them
// in the same order; counts samples dropped while both banks are full.
module afp_pingpong_buf
    import audio_frame_pkg::*;
#(
    parameter int FRAME_SAMPLES = 256,
    parameter int DATA_WIDTH    = 16,
    localparam int AW           = $clog2(FRAME_SAMPLES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_vld,
    input  logic                  rd_en,
    input  logic                  rd_bank,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rel_en,
    input  logic                  rel_bank,
    output logic [1:0]            bank_full,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);

    localparam logic [AW-1:0] LAST_PTR = AW'(FRAME_SAMPLES - 1);

    logic [DATA_WIDTH-1:0] mem [2*FRAME_SAMPLES];
    logic [DATA_WIDTH-1:0] rd_data_reg;

    logic          wr_bank_reg, wr_bank_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [1:0]    full_reg, full_next;
    logic          overflow_reg, overflow_next;
    logic [7:0]    drop_cnt_reg, drop_cnt_next;
    logic          wr_en;
    logic [AW:0]   wr_addr;

    always_comb begin
        wr_bank_next  = wr_bank_reg;
        wr_ptr_next   = wr_ptr_reg;
        full_next     = full_reg;
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        wr_en         = 1'b0;
        wr_addr       = {wr_bank_reg, wr_ptr_reg};

        if (!enable) begin
            wr_ptr_next = '0;
        end else if (sample_vld) begin
            // The write bank can only be full when the other one is too.
            if (full_reg[wr_bank_reg]) begin
                overflow_next = 1'b1;
                if (drop_cnt_reg != DROP_CNT_MAX) begin
                    drop_cnt_next = drop_cnt_reg + 8'd1;
                end
            end else begin
                wr_en = 1'b1;
                if (wr_ptr_reg == LAST_PTR) begin
                    full_next[wr_bank_reg] = 1'b1;
                    wr_bank_next           = ~wr_bank_reg;
                    wr_ptr_next            = '0;
                end else begin
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                end
            end
        end

        // Released bank is never the one being completed, so both may happen together.
        if (rel_en) begin
            full_next[rel_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_reg  <= 1'b0;
            wr_ptr_reg   <= '0;
            full_reg     <= 2'b00;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= 8'h00;
        end else begin
            wr_bank_reg  <= wr_bank_next;
            wr_ptr_reg   <= wr_ptr_next;
            full_reg     <= full_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= sample_in;
        end
        if (rd_en) begin
            rd_data_reg <= mem[{rd_bank, rd_addr}];
        end
    end

    assign rd_data   = rd_data_reg;
    assign bank_full = full_reg;
    assign overflow  = overflow_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: rtl/audio_frame_packer.sv
// Packs PCM samples into framed byte stream (magic, seq, payload) with valid/ready output.
// Define AUDIO_FRAME_CSUM_EN to append a 16-bit payload checksum to every frame.
module audio_frame_packer
    import audio_frame_pkg::*;
#(
    parameter int FRAME_SAMPLES = 256,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_vld,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_sof,
    output logic                  tx_eof,
    output logic                  overflow,
    output logic [7:0]            drop_cnt
);

    localparam int AW = $clog2(FRAME_SAMPLES);
    localparam logic [AW:0] HDR_LAST  = (AW+1)'(HDR_LEN - 1);
    localparam logic [AW:0] PAY_LAST  = (AW+1)'(2*FRAME_SAMPLES - 1);

    afp_state_t state_reg, state_next;
    logic [AW:0]  idx_reg, idx_next;
    logic         rd_bank_reg, rd_bank_next;
    logic [15:0]  seq_reg, seq_next;
    logic [7:0]   tx_data_reg, tx_data_next;
    logic         tx_valid_reg, tx_valid_next;
    logic         tx_sof_reg, tx_sof_next;
    logic         tx_eof_reg, tx_eof_next;
`ifdef AUDIO_FRAME_CSUM_EN
    logic [15:0]  csum_reg, csum_next;
`endif

    logic                  adv;
    logic                  eof_hs;
    logic                  rd_en;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [1:0]            bank_full;

    // Output register may take a new byte when empty or being consumed this cycle.
    assign adv    = !tx_valid_reg || tx_ready;
    assign eof_hs = tx_valid_reg && tx_ready && tx_eof_reg;

    afp_pingpong_buf #(
        .FRAME_SAMPLES (FRAME_SAMPLES),
        .DATA_WIDTH    (DATA_WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sample_in  (sample_in),
        .sample_vld (sample_vld),
        .rd_en      (rd_en),
        .rd_bank    (rd_bank_reg),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rel_en     (eof_hs),
        .rel_bank   (~rd_bank_reg),
        .bank_full  (bank_full),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        rd_bank_next  = rd_bank_reg;
        seq_next      = seq_reg;
        tx_data_next  = tx_data_reg;
        tx_valid_next = tx_valid_reg;
        tx_sof_next   = tx_sof_reg;
        tx_eof_next   = tx_eof_reg;
`ifdef AUDIO_FRAME_CSUM_EN
        csum_next     = csum_reg;
`endif
        rd_en         = 1'b0;
        rd_addr       = '0;

        if (eof_hs) begin
            seq_next = seq_reg + 16'd1;
        end
        if (adv) begin
            tx_valid_next = 1'b0;
            tx_sof_next   = 1'b0;
            tx_eof_next   = 1'b0;
        end

        case (state_reg)
            ST_IDLE: begin
                // rd_bank already points past the frame still awaiting its eof handshake,
                // so the next frame can start while that byte is stalled.
                if (bank_full[rd_bank_reg]) begin
                    state_next = ST_HDR;
                    idx_next   = '0;
                    rd_en      = 1'b1;
`ifdef AUDIO_FRAME_CSUM_EN
                    csum_next  = 16'h0000;
`endif
                end
            end

            ST_HDR: begin
                if (adv) begin
                    tx_valid_next = 1'b1;
                    tx_data_next  = hdr_byte(idx_reg[1:0], seq_reg);
                    tx_sof_next   = (idx_reg == '0);
                    if (idx_reg == HDR_LAST) begin
                        state_next = ST_PAYLOAD;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (adv) begin
                    tx_valid_next = 1'b1;
                    tx_data_next  = idx_reg[0] ? rd_data[7:0] : rd_data[15:8];
                    // Fetch the next sample while its predecessor's low byte goes out.
                    if (idx_reg[0]) begin
                        rd_en     = 1'b1;
                        rd_addr   = idx_reg[AW:1] + 1'b1;
`ifdef AUDIO_FRAME_CSUM_EN
                        csum_next = csum_reg + rd_data;
`endif
                    end
                    if (idx_reg == PAY_LAST) begin
`ifdef AUDIO_FRAME_CSUM_EN
                        state_next   = ST_CSUM;
                        idx_next     = '0;
`else
                        tx_eof_next  = 1'b1;
                        state_next   = ST_IDLE;
                        rd_bank_next = ~rd_bank_reg;
`endif
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end

            ST_CSUM: begin
`ifdef AUDIO_FRAME_CSUM_EN
                if (adv) begin
                    tx_valid_next = 1'b1;
                    tx_data_next  = idx_reg[0] ? csum_reg[7:0] : csum_reg[15:8];
                    if (idx_reg[0]) begin
                        tx_eof_next  = 1'b1;
                        state_next   = ST_IDLE;
                        rd_bank_next = ~rd_bank_reg;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
`else
                state_next = ST_IDLE;
`endif
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            rd_bank_reg  <= 1'b0;
            seq_reg      <= 16'h0000;
            tx_data_reg  <= 8'h00;
            tx_valid_reg <= 1'b0;
            tx_sof_reg   <= 1'b0;
            tx_eof_reg   <= 1'b0;
`ifdef AUDIO_FRAME_CSUM_EN
            csum_reg     <= 16'h0000;
`endif
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            rd_bank_reg  <= rd_bank_next;
            seq_reg      <= seq_next;
            tx_data_reg  <= tx_data_next;
            tx_valid_reg <= tx_valid_next;
            tx_sof_reg   <= tx_sof_next;
            tx_eof_reg   <= tx_eof_next;
`ifdef AUDIO_FRAME_CSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;
    assign tx_sof   = tx_sof_reg;
    assign tx_eof   = tx_eof_reg;

endmodule

// File: tb/tb_audio_frame_packer.sv
// Directed + randomized bench for audio_frame_packer against a frame-level reference model.
module tb_audio_frame_packer;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] sample_in = 16'h0000;
    logic        sample_vld = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_sof;
    logic        tx_eof;
    logic        overflow;
    logic [7:0]  drop_cnt;

    audio_frame_packer #(.FRAME_SAMPLES(N), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .sample_in  (sample_in),
        .sample_vld (sample_vld),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ready_mode = 0;      // 0: always ready, 1: random, 2: never ready
    int cyc = 0;
    int rx_bytes = 0;
    int rx_eof_cnt = 0;
    int last_eof_cyc = 0;
    logic expect_b2b = 1'b0;

    // Reference model: frames as byte lists {sof, eof, data}
    logic [15:0] partial_q[$];
    logic [9:0]  exp_q[$];
    int          frames_done = 0;
    logic [15:0] model_seq = 16'h0000;
    int          model_drops = 0;
    logic        model_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_frame();
        logic [15:0] s;
        logic [15:0] sum;
        logic        last;
        sum = 16'h0000;
        exp_q.push_back({2'b10, 8'hA5});
        exp_q.push_back({2'b00, 8'h5A});
        exp_q.push_back({2'b00, model_seq[15:8]});
        exp_q.push_back({2'b00, model_seq[7:0]});
        for (int i = 0; i < N; i++) begin
            s = partial_q[i];
            sum = sum + s;
`ifdef AUDIO_FRAME_CSUM_EN
            last = 1'b0;
`else
            last = (i == N - 1);
`endif
            exp_q.push_back({2'b00, s[15:8]});
            exp_q.push_back({1'b0, last, s[7:0]});
        end
`ifdef AUDIO_FRAME_CSUM_EN
        exp_q.push_back({2'b00, sum[15:8]});
        exp_q.push_back({2'b01, sum[7:0]});
`endif
        model_seq = model_seq + 16'd1;
        frames_done++;
        partial_q.delete();
    endtask

    task automatic feed(input logic [15:0] s);
        if (frames_done - rx_eof_cnt >= 2) begin
            model_ovf = 1'b1;
            if (model_drops < 255) model_drops++;
        end else begin
            partial_q.push_back(s);
            if (partial_q.size() == N) model_frame();
        end
        sample_in  = s;
        sample_vld = 1'b1;
        @(posedge clk); #1;
        sample_vld = 1'b0;
    endtask

    task automatic set_enable(input logic v);
        if (!v) partial_q.delete();
        enable = v;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_done", 32'(exp_q.size()), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    // Stream monitor: byte order/flags, stall stability, bubble-free frames.
    initial begin
        logic       stalled;
        logic [9:0] held;
        logic [9:0] e;
        int         last_cyc;
        stalled  = 1'b0;
        held     = '0;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("hold_valid", 32'(tx_valid), 1);
                    chk("hold_byte", 32'({tx_sof, tx_eof, tx_data}), 32'(held));
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte", 32'({tx_sof, tx_eof, tx_data}), 32'(e));
                        if (ready_mode == 0 && !tx_sof) chk("no_bubble", 32'(cyc), 32'(last_cyc + 1));
                        if (tx_sof && expect_b2b) chk("b2b_gap_ok", 32'(cyc - last_eof_cyc <= 2), 1);
                    end
                    last_cyc = cyc;
                    rx_bytes++;
                    if (tx_eof) begin
                        rx_eof_cnt++;
                        last_eof_cyc = cyc;
                    end
                end
                stalled = tx_valid && !tx_ready;
                held    = {tx_sof, tx_eof, tx_data};
            end
        end
    end

    initial begin
        int start;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_tx_sof", 32'(tx_sof), 0);
        chk("rst_tx_eof", 32'(tx_eof), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;

        // Directed frame and first-byte latency
        feed(16'h1234);
        feed(16'h5678);
        feed(16'h9ABC);
        feed(16'hDEF0);
        @(negedge clk); chk("lat_edge0_valid", 32'(tx_valid), 0);
        @(negedge clk); chk("lat_edge1_valid", 32'(tx_valid), 0);
        @(negedge clk); chk("lat_edge2_valid", 32'(tx_valid), 1);
        chk("lat_edge2_sof", 32'(tx_sof), 1);
        drain(200);

        // Two back-to-back frames, seq 1 and 2
        for (int i = 0; i < 2 * N; i++) feed(16'($urandom));
        expect_b2b = 1'b1;
        drain(200);
        expect_b2b = 1'b0;

        // Random back-pressure
        ready_mode = 1;
        for (int i = 0; i < 2 * N; i++) feed(16'($urandom));
        drain(2000);
        for (int i = 0; i < N; i++) feed(16'($urandom));
        drain(2000);
        ready_mode = 0;
        @(posedge clk); #1;

        // Overflow with stalled sink
        ready_mode = 2;
        @(posedge clk); #1;
        for (int i = 0; i < 3 * N; i++) feed(16'($urandom));
        chk("ovf_flag", 32'(overflow), 32'(model_ovf));
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'(model_drops));
        ready_mode = 0;
        drain(500);
        chk("ovf_flag_sticky", 32'(overflow), 32'(model_ovf));

        // Enable drop discards partial frame
        feed(16'($urandom));
        feed(16'($urandom));
        set_enable(1'b0);
        set_enable(1'b1);
        for (int i = 0; i < N; i++) feed(16'($urandom));
        drain(200);

        // Reset mid-payload
        start = rx_bytes;
        for (int i = 0; i < N; i++) feed(16'($urandom));
        for (int i = 0; i < 100 && rx_bytes < start + 6; i++) @(negedge clk);
        chk("mid_payload_reached", 32'(rx_bytes >= start + 6), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_tx_valid", 32'(tx_valid), 0);
        chk("mrst_tx_data", 32'(tx_data), 0);
        chk("mrst_tx_sof", 32'(tx_sof), 0);
        chk("mrst_tx_eof", 32'(tx_eof), 0);
        chk("mrst_overflow", 32'(overflow), 0);
        chk("mrst_drop_cnt", 32'(drop_cnt), 0);
        exp_q.delete();
        partial_q.delete();
        frames_done = 0;
        rx_eof_cnt  = 0;
        model_seq   = 16'h0000;
        model_drops = 0;
        model_ovf   = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) feed(16'($urandom));
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
